// File: rtl/sram_bank_arb.sv
// Two-requester arbiter in front of NUM_BANK single-port regfile SRAM banks.
// Each bank has its own round-robin bit. Grants are combinational, and read
// data comes straight from the bank outputs one cycle after the grant.

// Per-bank port mux: drives the bank from the requester selected for it.
module sram_bank_arb_bmux #(
  parameter int MW = 4,
  parameter int WW = 9,
  parameter int DW = 32
) (
  input  logic          i_sel0,
  input  logic          i_sel1,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [MW-1:0] i_bm0,
  input  logic [MW-1:0] i_bm1,
  input  logic [WW-1:0] i_word0,
  input  logic [WW-1:0] i_word1,
  input  logic [DW-1:0] i_wdat0,
  input  logic [DW-1:0] i_wdat1,
  output logic          o_en,
  output logic          o_wen,
  output logic [MW-1:0] o_bm,
  output logic [WW-1:0] o_addr,
  output logic [DW-1:0] o_dat
);
  // The two selects are mutually exclusive for any one bank. An idle bank is driven to all zeros.
  always_comb begin
    o_en   = 1'b0;
    o_wen  = 1'b0;
    o_bm   = '0;
    o_addr = '0;
    o_dat  = '0;
    if (i_sel0) begin
      o_en = 1'b1; o_wen = i_we0; o_bm = i_bm0; o_addr = i_word0; o_dat = i_wdat0;
    end else if (i_sel1) begin
      o_en = 1'b1; o_wen = i_we1; o_bm = i_bm1; o_addr = i_word1; o_dat = i_wdat1;
    end
  end
endmodule

module sram_bank_arb #(
  parameter int NUM_BANK   = 4,
  parameter int WORD_DEPTH = 512,
  parameter int DATA_WIDTH = 32,
  localparam int BW = $clog2(NUM_BANK),
  localparam int WW = $clog2(WORD_DEPTH),
  localparam int AW = BW + WW,
  localparam int MW = DATA_WIDTH / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 req_0_i,
  input  logic                                 we_0_i,
  input  logic [MW-1:0]                        bm_0_i,
  input  logic [AW-1:0]                        addr_0_i,
  input  logic [DATA_WIDTH-1:0]                wdat_0_i,
  output logic                                 gnt_0_o,
  output logic                                 rvalid_0_o,
  output logic [DATA_WIDTH-1:0]                rdat_0_o,
  input  logic                                 req_1_i,
  input  logic                                 we_1_i,
  input  logic [MW-1:0]                        bm_1_i,
  input  logic [AW-1:0]                        addr_1_i,
  input  logic [DATA_WIDTH-1:0]                wdat_1_i,
  output logic                                 gnt_1_o,
  output logic                                 rvalid_1_o,
  output logic [DATA_WIDTH-1:0]                rdat_1_o,
  output logic [NUM_BANK-1:0]                  bank_en_o,
  output logic [NUM_BANK-1:0]                  bank_wen_o,
  output logic [NUM_BANK-1:0][MW-1:0]          bank_bm_o,
  output logic [NUM_BANK-1:0][WW-1:0]          bank_addr_o,
  output logic [NUM_BANK-1:0][DATA_WIDTH-1:0]  bank_dat_o,
  input  logic [NUM_BANK-1:0][DATA_WIDTH-1:0]  bank_dat_i
);
  logic [BW-1:0]       w_bank0, w_bank1;
  logic                w_conf;
  logic [NUM_BANK-1:0] w_sel0, w_sel1;
  logic [NUM_BANK-1:0] r_rr_ptr;
  logic                r_rv0, r_rv1;
  logic [BW-1:0]       r_rb0, r_rb1;

  assign w_bank0 = addr_0_i[AW-1:WW];
  assign w_bank1 = addr_1_i[AW-1:WW];
  assign w_conf  = req_0_i & req_1_i & (w_bank0 == w_bank1);

  // On a conflict, that bank's rr bit names the winner. Every grant is forced low while reset is held.
  assign gnt_0_o = rst_n_i & req_0_i & (~w_conf | ~r_rr_ptr[w_bank0]);
  assign gnt_1_o = rst_n_i & req_1_i & (~w_conf |  r_rr_ptr[w_bank1]);

  // A bank's rr bit flips only after a cycle in which both requesters hit that bank.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)    r_rr_ptr <= '0;
    else if (w_conf) r_rr_ptr[w_bank0] <= ~r_rr_ptr[w_bank0];
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    assign w_sel0[b] = gnt_0_o & (w_bank0 == BW'(b));
    assign w_sel1[b] = gnt_1_o & (w_bank1 == BW'(b));
    sram_bank_arb_bmux #(.MW(MW), .WW(WW), .DW(DATA_WIDTH)) u_bmux (
      .i_sel0 (w_sel0[b]),          .i_sel1 (w_sel1[b]),
      .i_we0  (we_0_i),             .i_we1  (we_1_i),
      .i_bm0  (bm_0_i),             .i_bm1  (bm_1_i),
      .i_word0(addr_0_i[WW-1:0]),   .i_word1(addr_1_i[WW-1:0]),
      .i_wdat0(wdat_0_i),           .i_wdat1(wdat_1_i),
      .o_en   (bank_en_o[b]),       .o_wen  (bank_wen_o[b]),
      .o_bm   (bank_bm_o[b]),       .o_addr (bank_addr_o[b]),
      .o_dat  (bank_dat_o[b])
    );
  end

  // Record which bank each granted read went to, so the return mux can pick that bank's output next cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rv0 <= 1'b0; r_rb0 <= '0;
      r_rv1 <= 1'b0; r_rb1 <= '0;
    end else begin
      r_rv0 <= gnt_0_o & ~we_0_i; r_rb0 <= w_bank0;
      r_rv1 <= gnt_1_o & ~we_1_i; r_rb1 <= w_bank1;
    end
  end

  assign rvalid_0_o = r_rv0;
  assign rvalid_1_o = r_rv1;
  assign rdat_0_o   = r_rv0 ? bank_dat_i[r_rb0] : '0;
  assign rdat_1_o   = r_rv1 ? bank_dat_i[r_rb1] : '0;
endmodule

// File: tb/tb_sram_bank_arb.sv
// Testbench for sram_bank_arb: behavioural SRAM banks, a flat reference
// memory with per-bank round-robin bits, and a read-data scoreboard.
module tb_sram_bank_arb;
  localparam int NB = 4, WD = 512, DW = 32, WW = 9, AW = 11, MW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [MW-1:0] bm0 = 0, bm1 = 0;
  logic [AW-1:0] addr0 = 0, addr1 = 0;
  logic [DW-1:0] wdat0 = 0, wdat1 = 0;
  logic gnt0, gnt1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic [NB-1:0] bank_en, bank_wen;
  logic [NB-1:0][MW-1:0] bank_bm;
  logic [NB-1:0][WW-1:0] bank_addr;
  logic [NB-1:0][DW-1:0] bank_dat, sram_q;

  sram_bank_arb dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_0_i(req0), .we_0_i(we0), .bm_0_i(bm0), .addr_0_i(addr0), .wdat_0_i(wdat0),
    .gnt_0_o(gnt0), .rvalid_0_o(rv0), .rdat_0_o(rd0),
    .req_1_i(req1), .we_1_i(we1), .bm_1_i(bm1), .addr_1_i(addr1), .wdat_1_i(wdat1),
    .gnt_1_o(gnt1), .rvalid_1_o(rv1), .rdat_1_o(rd1),
    .bank_en_o(bank_en), .bank_wen_o(bank_wen), .bank_bm_o(bank_bm),
    .bank_addr_o(bank_addr), .bank_dat_o(bank_dat), .bank_dat_i(sram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(int a);
    return 32'(32'h9E3779B9 * (a + 1));
  endfunction

  // Behavioural SRAM banks; the first edge loads the same pattern the reference memory starts with
  logic [DW-1:0] sram [NB][WD];
  logic sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int b = 0; b < NB; b++)
        for (int w = 0; w < WD; w++) sram[b][w] <= pat(b * WD + w);
      sram_init <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++)
        if (bank_en[b]) begin
          if (bank_wen[b]) begin
            for (int k = 0; k < MW; k++)
              if (bank_bm[b][k]) sram[b][bank_addr[b]][8*k +: 8] <= bank_dat[b][8*k +: 8];
          end else sram_q[b] <= sram[b][bank_addr[b]];
        end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: flat memory, one round-robin bit per bank, expected read queues
  typedef struct { logic [DW-1:0] d; int due; } exp_t;
  exp_t q0[$], q1[$];
  logic [DW-1:0] ref_mem [2**AW];
  bit ref_ptr [NB];
  int wait0 = 0, wait1 = 0;
  int checks = 0, failures = 0;
  logic last_g0, last_g1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic int bk(logic [AW-1:0] a);
    return int'(a[AW-1:WW]);
  endfunction

  task automatic ref_write(logic [AW-1:0] a, logic [MW-1:0] m, logic [DW-1:0] d);
    for (int k = 0; k < MW; k++) if (m[k]) ref_mem[a][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic flush_model();
    q0.delete(); q1.delete();
    for (int b = 0; b < NB; b++) ref_ptr[b] = 0;
    wait0 = 0; wait1 = 0;
  endtask

  // One cycle: inputs already set at posedge+1. Check grants and bank ports, update the model, then advance.
  task automatic do_cycle(input bit assert_rst, output bit g0, output bit g1);
    bit conf;
    logic e_en, e_wen; logic [MW-1:0] e_bm; logic [WW-1:0] e_ad; logic [DW-1:0] e_d;
    #3;
    conf = req0 && req1 && (bk(addr0) == bk(addr1));
    g0 = rst_n && req0 && (!conf || ref_ptr[bk(addr0)] == 0);
    g1 = rst_n && req1 && (!conf || ref_ptr[bk(addr1)] == 1);
    last_g0 = gnt0; last_g1 = gnt1;
    chk("gnt0", gnt0, g0);
    chk("gnt1", gnt1, g1);
    for (int b = 0; b < NB; b++) begin
      e_en = 0; e_wen = 0; e_bm = 0; e_ad = 0; e_d = 0;
      if (g0 && bk(addr0) == b) begin
        e_en = 1; e_wen = we0; e_bm = bm0; e_ad = addr0[WW-1:0]; e_d = wdat0;
      end else if (g1 && bk(addr1) == b) begin
        e_en = 1; e_wen = we1; e_bm = bm1; e_ad = addr1[WW-1:0]; e_d = wdat1;
      end
      chk($sformatf("bank%0d_en", b), bank_en[b], e_en);
      chk($sformatf("bank%0d_port", b), {bank_wen[b], bank_bm[b], bank_addr[b], bank_dat[b]},
          {e_wen, e_bm, e_ad, e_d});
    end
    if (g0 && !we0) q0.push_back('{ref_mem[addr0], cyc + 1});
    if (g1 && !we1) q1.push_back('{ref_mem[addr1], cyc + 1});
    if (g0 && we0) ref_write(addr0, bm0, wdat0);
    if (g1 && we1) ref_write(addr1, bm1, wdat1);
    if (conf && rst_n) ref_ptr[bk(addr0)] = !ref_ptr[bk(addr0)];
    wait0 = (req0 && !g0 && rst_n) ? wait0 + 1 : 0;
    wait1 = (req1 && !g1 && rst_n) ? wait1 + 1 : 0;
    chk("wait_bound", {wait0 > 1, wait1 > 1}, 2'b00);
    if (assert_rst) begin
      rst_n = 1'b0;
      flush_model();
    end
    @(posedge clk); #1;
  endtask

  task automatic set0(bit r, bit w, logic [MW-1:0] m, logic [AW-1:0] a, logic [DW-1:0] d);
    req0 = r; we0 = w; bm0 = m; addr0 = a; wdat0 = d;
  endtask
  task automatic set1(bit r, bit w, logic [MW-1:0] m, logic [AW-1:0] a, logic [DW-1:0] d);
    req1 = r; we1 = w; bm1 = m; addr1 = a; wdat1 = d;
  endtask

  // Reset with both requests asserted: grants and bank ports must stay low
  task automatic do_reset();
    bit g0, g1;
    rst_n = 1'b0;
    flush_model();
    set0(1, 0, 0, 11'h004, 0); set1(1, 1, 4'hF, 11'h004, 32'h1);
    repeat (3) do_cycle(0, g0, g1);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: reads are due exactly one cycle after their grant
  always @(negedge clk) begin
    if (q0.size() > 0 && q0[0].due == cyc) begin
      chk("rvalid0", rv0, 1'b1); chk("rdat0", rd0, q0[0].d); void'(q0.pop_front());
    end else begin
      chk("rvalid0_idle", rv0, 1'b0); chk("rdat0_idle", rd0, 0);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("rvalid1", rv1, 1'b1); chk("rdat1", rd1, q1[0].d); void'(q1.pop_front());
    end else begin
      chk("rvalid1_idle", rv1, 1'b0); chk("rdat1_idle", rd1, 0);
    end
  end

  initial begin
    bit g0, g1, p0, p1;
    for (int a = 0; a < 2**AW; a++) ref_mem[a] = pat(a);
    @(posedge clk); #1;
    do_reset();

    // Write then read back on requester 0
    set0(1, 1, 4'hF, 11'h005, 32'hDEADBEEF); do_cycle(0, g0, g1);
    set0(1, 0, 4'h0, 11'h005, 0);            do_cycle(0, g0, g1);
    set0(0, 0, 0, 0, 0);
    chk("t_wr_rd_rdat", {rv0, rd0}, {1'b1, 32'hDEADBEEF});
    do_cycle(0, g0, g1);

    // Parallel reads to different banks
    set0(1, 0, 0, 11'h000, 0); set1(1, 0, 0, 11'h200, 0);
    do_cycle(0, g0, g1);
    chk("t_par_gnt", {last_g0, last_g1}, 2'b11);
    chk("t_par_rv", {rv0, rv1}, 2'b11);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    do_cycle(0, g0, g1);

    // Held conflict on bank 2 from reset: winners 0,1,0,1, then 0 again
    do_reset();
    set0(1, 0, 0, 11'h400, 0); set1(1, 0, 0, 11'h401, 0);
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, g0, g1);
      chk($sformatf("t_rr_gnt%0d", i), {last_g0, last_g1}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    do_cycle(0, g0, g1);

    // Partial byte write
    set0(1, 1, 4'hF, 11'h0A0, 32'hAABBCCDD); do_cycle(0, g0, g1);
    set0(1, 1, 4'h3, 11'h0A0, 32'h11223344); do_cycle(0, g0, g1);
    set0(1, 0, 4'h0, 11'h0A0, 0);            do_cycle(0, g0, g1);
    set0(0, 0, 0, 0, 0);
    chk("t_bm_rdat", rd0, 32'hAABB3344);
    do_cycle(0, g0, g1);

    // Reset lands on an in-flight read
    set0(1, 0, 0, 11'h010, 0); do_cycle(1, g0, g1);
    do_cycle(0, g0, g1); do_cycle(0, g0, g1);
    chk("t_rst_en", bank_en, 4'h0);
    rst_n = 1'b1;
    set0(0, 0, 0, 0, 0);
    do_cycle(0, g0, g1);
    chk("t_rst_rv", {rv0, rv1}, 2'b00);

    // Random traffic on a few words per bank so conflicts and same-word hazards are frequent
    p0 = 0; p1 = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!p0) begin
        if ($urandom_range(3) != 0)
          set0(1, $urandom_range(4) < 2, MW'($urandom),
               {2'($urandom_range(NB - 1)), 9'($urandom_range(3))}, $urandom);
        else set0(0, 0, 0, 0, 0);
      end
      if (!p1) begin
        if ($urandom_range(3) != 0)
          set1(1, $urandom_range(4) < 2, MW'($urandom),
               {2'($urandom_range(NB - 1)), 9'($urandom_range(3))}, $urandom);
        else set1(0, 0, 0, 0, 0);
      end
      do_cycle(0, g0, g1);
      p0 = req0 && !g0;
      p1 = req1 && !g1;
    end
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    do_cycle(0, g0, g1); do_cycle(0, g0, g1);
    chk("q_drained", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
